// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for the dual-port scratch RAM.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package dual_port_ram_pkg;

    // Result returned by a read that collides with a write from the other port.
    localparam int RDW_READ_FIRST  = 0;  // old contents
    localparam int RDW_WRITE_FIRST = 1;  // merged post-write contents

    // Clear engine state: CLEAR zeroes the array, RUN accepts requests.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    // Resolves one byte lane when both ports may write it in the same cycle.
    // Port 2 is applied first, so port 1 overrides it wherever both strobe.
    function automatic logic [7:0] merge_lane(
        input logic [7:0] old_byte,
        input logic [7:0] p1_byte,
        input logic       p1_en,
        input logic [7:0] p2_byte,
        input logic       p2_en
    );
        logic [7:0] res;
        res = old_byte;
        if (p2_en) res = p2_byte;
        if (p1_en) res = p1_byte;
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: sweeps clear_addr 0..SIZE-1 after reset, then raises ready.
// Latency: exactly SIZE cycles from reset release to ready.
// Backpressure: ready low during the sweep; the top level ignores requests then.
// Ports: clk, rst (async, active-high) in; ready, clear_addr out.
module ram_clear_ctrl #(
    parameter int SIZE           = 4096,
    parameter int ADDR_WIDTH     = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] clear_addr
);
    import dual_port_ram_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(SIZE - 1);
    localparam ram_state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    ram_state_t            state;
    ram_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] clear_addr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_STATE;
            clear_addr <= '0;
        end else begin
            state      <= state_nxt;
            clear_addr <= clear_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        clear_addr_nxt = clear_addr;
        case (state)
            CLEAR: begin
                clear_addr_nxt = clear_addr + ADDR_WIDTH'(1);
                // The cycle that zeroes the last word hands over to RUN.
                if (clear_addr == LAST_ADDR) state_nxt = RUN;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign ready = (state == RUN);

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with byte strobes, registered reads and a post-reset clear.
// Latency: read data/rvalid one cycle after an accepted read; writes visible next cycle.
// Backpressure: ready low while clearing; requests are dropped (not stalled) then.
// Ports: clk, rst, ready; per port N: req_N, addr_N, wdata_N, wstrb_N (0 = read) in,
//        rdata_N (held until next read), rvalid_N (one-cycle pulse per read) out.
module dual_port_ram #(
    parameter int SIZE           = 4096,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(SIZE),
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    req_1,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    input  logic [DATA_WIDTH/8-1:0] wstrb_1,
    output logic [DATA_WIDTH-1:0]   rdata_1,
    output logic                    rvalid_1,
    input  logic                    req_2,
    input  logic [ADDR_WIDTH-1:0]   addr_2,
    input  logic [DATA_WIDTH-1:0]   wdata_2,
    input  logic [DATA_WIDTH/8-1:0] wstrb_2,
    output logic [DATA_WIDTH-1:0]   rdata_2,
    output logic                    rvalid_2
);
    import dual_port_ram_pkg::*;

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic [ADDR_WIDTH-1:0] clear_addr;

    ram_clear_ctrl #(
        .SIZE           (SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .clear_addr (clear_addr)
    );

    // Effective write port 1: carries the clear sweep until ready rises.
    logic                  wr1_en;
    logic [ADDR_WIDTH-1:0] wa1;
    logic [DATA_WIDTH-1:0] wd1;
    logic [NB-1:0]         ws1;
    logic                  wr2_en;
    logic                  rd1_en;
    logic                  rd2_en;
    logic                  in_range_1;
    logic                  in_range_2;

    // Only matters for non-power-of-two SIZE; trivially true otherwise.
    assign in_range_1 = ({1'b0, addr_1} < (ADDR_WIDTH + 1)'(SIZE));
    assign in_range_2 = ({1'b0, addr_2} < (ADDR_WIDTH + 1)'(SIZE));

    always_comb begin
        wa1    = addr_1;
        wd1    = wdata_1;
        ws1    = wstrb_1;
        wr1_en = ready && req_1 && (wstrb_1 != '0) && in_range_1;
        if (!ready) begin
            wr1_en = 1'b1;
            wa1    = clear_addr;
            wd1    = '0;
            ws1    = '1;
        end
        wr2_en = ready && req_2 && (wstrb_2 != '0) && in_range_2;
        rd1_en = ready && req_1 && (wstrb_1 == '0);
        rd2_en = ready && req_2 && (wstrb_2 == '0);
    end

    // Port 1 lanes are assigned after port 2 lanes, so port 1 wins a shared lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr2_en && wstrb_2[i]) mem[addr_2][8*i +: 8] <= wdata_2[8*i +: 8];
            if (wr1_en && ws1[i])     mem[wa1][8*i +: 8]    <= wd1[8*i +: 8];
        end
    end

    // Read words: old contents, or with the same-cycle writes folded in when
    // write-first is selected. Out-of-range reads return zero.
    logic [DATA_WIDTH-1:0] rd_word_1;
    logic [DATA_WIDTH-1:0] rd_word_2;
    logic [DATA_WIDTH-1:0] old_1;
    logic [DATA_WIDTH-1:0] old_2;

    always_comb begin
        rd_word_1 = '0;
        rd_word_2 = '0;
        old_1     = '0;
        old_2     = '0;
        if (in_range_1) begin
            old_1 = mem[addr_1];
            rd_word_1 = old_1;
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                for (int i = 0; i < NB; i++) begin
                    rd_word_1[8*i +: 8] = merge_lane(old_1[8*i +: 8],
                        wd1[8*i +: 8], wr1_en && ws1[i] && (wa1 == addr_1),
                        wdata_2[8*i +: 8], wr2_en && wstrb_2[i] && (addr_2 == addr_1));
                end
            end
        end
        if (in_range_2) begin
            old_2 = mem[addr_2];
            rd_word_2 = old_2;
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                for (int i = 0; i < NB; i++) begin
                    rd_word_2[8*i +: 8] = merge_lane(old_2[8*i +: 8],
                        wd1[8*i +: 8], wr1_en && ws1[i] && (wa1 == addr_2),
                        wdata_2[8*i +: 8], wr2_en && wstrb_2[i] && (addr_2 == addr_2));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_1  <= '0;
            rvalid_1 <= 1'b0;
            rdata_2  <= '0;
            rvalid_2 <= 1'b0;
        end else begin
            rvalid_1 <= rd1_en;
            rvalid_2 <= rd2_en;
            if (rd1_en) rdata_1 <= rd_word_1;
            if (rd2_en) rdata_2 <= rd_word_2;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_1, req_2;
    logic [3:0]  addr_1, addr_2;
    logic [31:0] wdata_1, wdata_2;
    logic [3:0]  wstrb_1, wstrb_2;

    // dut0: SIZE=16 read-first; dut1: SIZE=12 write-first. Both share stimulus.
    logic        ready0, ready1;
    logic [31:0] rd0_1, rd0_2, rd1_1, rd1_2;
    logic        rv0_1, rv0_2, rv1_1, rv1_2;

    dual_port_ram #(.SIZE(16), .DATA_WIDTH(32), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .wstrb_1(wstrb_1),
        .rdata_1(rd0_1), .rvalid_1(rv0_1),
        .req_2(req_2), .addr_2(addr_2), .wdata_2(wdata_2), .wstrb_2(wstrb_2),
        .rdata_2(rd0_2), .rvalid_2(rv0_2));

    dual_port_ram #(.SIZE(12), .DATA_WIDTH(32), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .wstrb_1(wstrb_1),
        .rdata_1(rd1_1), .rvalid_1(rv1_1),
        .req_2(req_2), .addr_2(addr_2), .wdata_2(wdata_2), .wstrb_2(wstrb_2),
        .rdata_2(rd1_2), .rvalid_2(rv1_2));

    // Reference model: one word array per DUT plus expected outputs.
    logic [31:0] m      [2][16];
    int          sz     [2];
    int          rdw    [2];
    bit          rdy_e  [2];
    int          cnt    [2];
    logic [31:0] rd_e   [2][2];
    bit          rv_e   [2][2];

    // Current request per port (index 0 = port 1, 1 = port 2).
    bit          mreq   [2];
    logic [3:0]  maddr  [2];
    logic [31:0] mdata  [2];
    logic [3:0]  mstrb  [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int d, input logic rdy, input logic v1, input logic [31:0] r1,
                           input logic v2, input logic [31:0] r2);
        chk($sformatf("d%0d_ready", d),   32'(rdy), 32'(rdy_e[d]));
        chk($sformatf("d%0d_rvalid1", d), 32'(v1),  32'(rv_e[d][0]));
        chk($sformatf("d%0d_rdata1", d),  r1,       rd_e[d][0]);
        chk($sformatf("d%0d_rvalid2", d), 32'(v2),  32'(rv_e[d][1]));
        chk($sformatf("d%0d_rdata2", d),  r2,       rd_e[d][1]);
    endtask

    task automatic check_outputs();
        chk_dut(0, ready0, rv0_1, rd0_1, rv0_2, rd0_2);
        chk_dut(1, ready1, rv1_1, rd1_1, rv1_2, rd1_2);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rdy_e[d] = 1'b0;
            cnt[d]   = 0;
            for (int p = 0; p < 2; p++) begin
                rd_e[d][p] = 32'h0;
                rv_e[d][p] = 1'b0;
            end
        end
    endtask

    // Advance the model by one rising edge using the current requests.
    task automatic model_edge();
        logic [31:0] nm [16];
        int          a;
        for (int d = 0; d < 2; d++) begin
            if (!rdy_e[d]) begin
                m[d][cnt[d]] = 32'h0;
                cnt[d]++;
                if (cnt[d] == sz[d]) rdy_e[d] = 1'b1;
                rv_e[d][0] = 1'b0;
                rv_e[d][1] = 1'b0;
            end else begin
                for (int i = 0; i < 16; i++) nm[i] = m[d][i];
                // Port 2 first, then port 1, so port 1 owns shared lanes.
                for (int p = 1; p >= 0; p--) begin
                    a = int'(maddr[p]);
                    if (mreq[p] && mstrb[p] != 4'h0 && a < sz[d])
                        for (int l = 0; l < 4; l++)
                            if (mstrb[p][l]) nm[a][8*l +: 8] = mdata[p][8*l +: 8];
                end
                for (int p = 0; p < 2; p++) begin
                    a = int'(maddr[p]);
                    rv_e[d][p] = mreq[p] && (mstrb[p] == 4'h0);
                    if (rv_e[d][p])
                        rd_e[d][p] = (a >= sz[d]) ? 32'h0 : ((rdw[d] == 1) ? nm[a] : m[d][a]);
                end
                for (int i = 0; i < 16; i++) m[d][i] = nm[i];
            end
        end
    endtask

    task automatic cycle(input logic r1, input logic [3:0] a1, input logic [31:0] d1, input logic [3:0] s1,
                         input logic r2, input logic [3:0] a2, input logic [31:0] d2, input logic [3:0] s2);
        req_1 = r1; addr_1 = a1; wdata_1 = d1; wstrb_1 = s1;
        req_2 = r2; addr_2 = a2; wdata_2 = d2; wstrb_2 = s2;
        mreq[0] = r1; maddr[0] = a1; mdata[0] = d1; mstrb[0] = s1;
        mreq[1] = r2; maddr[1] = a2; mdata[1] = d2; mstrb[1] = s2;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic readback_all();
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 4'(i), 32'h0, 4'h0, 1'b1, 4'(15 - i), 32'h0, 4'h0);
        idle();
    endtask

    initial begin
        sz[0] = 16; sz[1] = 12;
        rdw[0] = 0; rdw[1] = 1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) m[d][i] = 32'h0;
        req_1 = 1'b0; addr_1 = 4'h0; wdata_1 = 32'h0; wstrb_1 = 4'h0;
        req_2 = 1'b0; addr_2 = 4'h0; wdata_2 = 32'h0; wstrb_2 = 4'h0;

        // Reset, then restart the clear at clear cycle 5.
        do_reset();
        for (int i = 0; i < 5; i++) idle();
        do_reset();

        // Full clear; a write and a read issued mid-clear must be ignored.
        for (int i = 1; i <= 16; i++) begin
            if (i == 10) cycle(1'b1, 4'h2, 32'h5A5A5A5A, 4'hF, 1'b1, 4'h1, 32'h0, 4'h0);
            else idle();
            if (i == 10) chk("clear_req_no_rvalid", 32'(rv0_1), 32'h0);
            if (i == 11) chk("d1_ready_before_12", 32'(ready1), 32'h0);
            if (i == 12) chk("d1_ready_after_12", 32'(ready1), 32'h1);
            if (i == 15) chk("d0_ready_before_16", 32'(ready0), 32'h0);
            if (i == 16) chk("d0_ready_after_16", 32'(ready0), 32'h1);
        end

        // Every word reads back as zero (including addr 2 written during clear).
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'(i), 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'h0);
            chk($sformatf("clear_zero_%0d", i), rd0_1, 32'h0);
        end
        idle();

        // Byte strobes.
        cycle(1'b1, 4'h3, 32'hAABBCCDD, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0);
        chk("wr_no_rvalid", 32'(rv0_1), 32'h0);
        cycle(1'b1, 4'h3, 32'h11223344, 4'b0101, 1'b0, 4'h0, 32'h0, 4'h0);
        cycle(1'b1, 4'h3, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk("strobe_rdata", rd0_1, 32'hAA22CC44);
        chk("strobe_rvalid", 32'(rv0_1), 32'h1);
        idle();
        chk("rvalid_pulse", 32'(rv0_1), 32'h0);
        chk("rdata_hold", rd0_1, 32'hAA22CC44);

        // Dual-write collision on addr 7.
        cycle(1'b1, 4'h7, 32'h11111111, 4'b0011, 1'b1, 4'h7, 32'h22222222, 4'b0110);
        cycle(1'b1, 4'h7, 32'h0, 4'h0, 1'b1, 4'h7, 32'h0, 4'h0);
        chk("collide_d0", rd0_1, 32'h00221111);
        chk("collide_d1", rd1_2, 32'h00221111);

        // Read-during-write across ports.
        cycle(1'b1, 4'h5, 32'hDEADBEEF, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0);
        cycle(1'b1, 4'h5, 32'hCAFEF00D, 4'hF, 1'b1, 4'h5, 32'h0, 4'h0);
        chk("rdw_read_first", rd0_2, 32'hDEADBEEF);
        chk("rdw_write_first", rd1_2, 32'hCAFEF00D);

        // Out of range on the SIZE=12 instance.
        cycle(1'b1, 4'hD, 32'h00000005, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0);
        cycle(1'b1, 4'hD, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk("oor_rdata", rd1_1, 32'h0);
        chk("oor_rvalid", 32'(rv1_1), 32'h1);
        readback_all();

        // Randomized traffic with frequent address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  a1, a2, s1, s2;
            logic [31:0] dd1, dd2;
            logic        r1, r2;
            r1  = 1'($urandom_range(0, 1));
            r2  = 1'($urandom_range(0, 1));
            a1  = 4'($urandom_range(0, 15));
            a2  = ($urandom_range(0, 1) == 1) ? a1 : 4'($urandom_range(0, 15));
            s1  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            s2  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            dd1 = $urandom;
            dd2 = $urandom;
            cycle(r1, a1, dd1, s1, r2, a2, dd2, s2);
        end
        readback_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
